// File: rtl/l1_snoop_responder.sv
// L1 snoop responder: serves L2 coherency snoops against the L1 tag/state
// array, applies the MESI downgrade/invalidate, returns dirty line data.
module l1_snoop_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned L1_SETS    = 64,
  parameter int unsigned L1_WAYS    = 4,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IDX_W = $clog2(L1_SETS),
  localparam int unsigned WAY_W = $clog2(L1_WAYS),
  localparam int unsigned OFF_W = $clog2(LINE_BYTES),
  localparam int unsigned TAG_W = ADDR_WIDTH - OFF_W - IDX_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  snoop_valid_i,
  output logic                  snoop_ready_o,
  input  logic [ADDR_WIDTH-1:0] snoop_addr_i,
  input  logic [1:0]            snoop_type_i,
  output logic                  snoop_rsp_valid_o,
  output logic                  snoop_rsp_hit_o,
  output logic                  snoop_rsp_data_valid_o,
  output logic [DATA_WIDTH-1:0] snoop_rsp_data_o,
  output logic                  arr_req_o,
  input  logic                  arr_gnt_i,
  output logic                  tag_rd_en_o,
  output logic [IDX_W-1:0]      tag_rd_idx_o,
  output logic [TAG_W-1:0]      tag_rd_tag_o,
  input  logic                  tag_rd_hit_i,
  input  logic [WAY_W-1:0]      tag_rd_way_i,
  input  logic [1:0]            tag_rd_state_i,
  output logic                  st_wr_en_o,
  output logic [IDX_W-1:0]      st_wr_idx_o,
  output logic [WAY_W-1:0]      st_wr_way_o,
  output logic [1:0]            st_wr_state_o,
  output logic                  data_rd_en_o,
  output logic [IDX_W-1:0]      data_rd_idx_o,
  output logic [WAY_W-1:0]      data_rd_way_o,
  input  logic [DATA_WIDTH-1:0] data_rd_data_i,
  output logic [CNT_WIDTH-1:0]  snoop_hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  snoop_wb_cnt_o
);

  localparam logic [1:0] SNP_READ = 2'b00;
  localparam logic [1:0] SNP_RSVD = 2'b11;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    TAG_CHK  = 3'd2,
    DATA_CAP = 3'd3,
    RESP     = 3'd4
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            type_q;
  logic                  hit_q;
  logic                  dv_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic [CNT_WIDTH-1:0]  wb_cnt_q;

  logic       line_hit;
  logic       wr_chg;
  logic [1:0] wr_state;
  logic       need_data;
  logic       in_chk;
  logic [IDX_W-1:0] snp_idx;

  assign snp_idx = addr_q[OFF_W +: IDX_W];

  // MESI transition decode for the line returned by the tag lookup
  always_comb begin
    line_hit  = 1'b0;
    wr_chg    = 1'b0;
    wr_state  = MESI_I;
    need_data = 1'b0;
    if (tag_rd_hit_i && (tag_rd_state_i != MESI_I)) begin
      line_hit  = 1'b1;
      need_data = (tag_rd_state_i == MESI_M);
      if (type_q == SNP_READ) begin
        if (tag_rd_state_i != MESI_S) begin
          wr_chg   = 1'b1;
          wr_state = MESI_S;
        end
      end else begin
        wr_chg   = 1'b1;
        wr_state = MESI_I;
      end
    end
  end

  // Array strobes are suppressed in a reset cycle so an abandoned snoop leaves the array untouched
  assign in_chk        = (state_q == TAG_CHK) && !rst_i;
  assign snoop_ready_o = (state_q == IDLE);
  assign arr_req_o     = (state_q == LOOKUP) || (state_q == TAG_CHK);
  assign tag_rd_en_o   = (state_q == LOOKUP) && arr_gnt_i;
  assign tag_rd_idx_o  = snp_idx;
  assign tag_rd_tag_o  = addr_q[ADDR_WIDTH-1 -: TAG_W];

  assign st_wr_en_o    = in_chk && wr_chg;
  assign st_wr_idx_o   = st_wr_en_o ? snp_idx : '0;
  assign st_wr_way_o   = st_wr_en_o ? tag_rd_way_i : '0;
  assign st_wr_state_o = st_wr_en_o ? wr_state : 2'b00;

  assign data_rd_en_o  = in_chk && need_data;
  assign data_rd_idx_o = data_rd_en_o ? snp_idx : '0;
  assign data_rd_way_o = data_rd_en_o ? tag_rd_way_i : '0;

  assign snoop_rsp_valid_o      = (state_q == RESP);
  assign snoop_rsp_hit_o        = (state_q == RESP) && hit_q;
  assign snoop_rsp_data_valid_o = (state_q == RESP) && dv_q;
  assign snoop_rsp_data_o       = ((state_q == RESP) && dv_q) ? data_q : '0;

  assign snoop_hit_cnt_o = hit_cnt_q;
  assign snoop_wb_cnt_o  = wb_cnt_q;

  // Snoop sequencing FSM with captured request, response flags and statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      type_q    <= 2'b00;
      hit_q     <= 1'b0;
      dv_q      <= 1'b0;
      data_q    <= '0;
      hit_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snoop_valid_i) begin
            addr_q  <= snoop_addr_i;
            type_q  <= snoop_type_i;
            hit_q   <= 1'b0;
            dv_q    <= 1'b0;
            data_q  <= '0;
            state_q <= (snoop_type_i == SNP_RSVD) ? RESP : LOOKUP;
          end
        end
        LOOKUP: begin
          if (arr_gnt_i) state_q <= TAG_CHK;
        end
        TAG_CHK: begin
          hit_q   <= line_hit;
          dv_q    <= need_data;
          state_q <= need_data ? DATA_CAP : RESP;
        end
        DATA_CAP: begin
          data_q  <= data_rd_data_i;
          state_q <= RESP;
        end
        RESP: begin
          if (hit_q && (hit_cnt_q != {CNT_WIDTH{1'b1}}))
            hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
          if (dv_q && (wb_cnt_q != {CNT_WIDTH{1'b1}}))
            wb_cnt_q <= wb_cnt_q + CNT_WIDTH'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Directed bench for l1_snoop_responder: vector table plus grant-stall,
// mid-snoop reset and counter saturation sequences.
module tb_l1_snoop_responder;

  logic         clk_i;
  logic         rst_i;
  logic         snoop_valid_i;
  logic         snoop_ready_o;
  logic [31:0]  snoop_addr_i;
  logic [1:0]   snoop_type_i;
  logic         snoop_rsp_valid_o;
  logic         snoop_rsp_hit_o;
  logic         snoop_rsp_data_valid_o;
  logic [255:0] snoop_rsp_data_o;
  logic         arr_req_o;
  logic         arr_gnt_i;
  logic         tag_rd_en_o;
  logic [5:0]   tag_rd_idx_o;
  logic [20:0]  tag_rd_tag_o;
  logic         tag_rd_hit_i;
  logic [1:0]   tag_rd_way_i;
  logic [1:0]   tag_rd_state_i;
  logic         st_wr_en_o;
  logic [5:0]   st_wr_idx_o;
  logic [1:0]   st_wr_way_o;
  logic [1:0]   st_wr_state_o;
  logic         data_rd_en_o;
  logic [5:0]   data_rd_idx_o;
  logic [1:0]   data_rd_way_o;
  logic [255:0] data_rd_data_i;
  logic [15:0]  snoop_hit_cnt_o;
  logic [15:0]  snoop_wb_cnt_o;

  // Narrow-counter twin sharing all stimulus, used for saturation checks
  logic         s_ready, s_rv, s_rh, s_rdv, s_req, s_tre, s_swe, s_dre;
  logic [255:0] s_rdata;
  logic [5:0]   s_tidx, s_sidx, s_didx;
  logic [20:0]  s_ttag;
  logic [1:0]   s_sway, s_sst, s_dway;
  logic [1:0]   s_hcnt, s_wcnt;

  logic gnt_allow;
  assign arr_gnt_i = arr_req_o & gnt_allow;

  l1_snoop_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .snoop_valid_i(snoop_valid_i), .snoop_ready_o(snoop_ready_o),
    .snoop_addr_i(snoop_addr_i), .snoop_type_i(snoop_type_i),
    .snoop_rsp_valid_o(snoop_rsp_valid_o), .snoop_rsp_hit_o(snoop_rsp_hit_o),
    .snoop_rsp_data_valid_o(snoop_rsp_data_valid_o), .snoop_rsp_data_o(snoop_rsp_data_o),
    .arr_req_o(arr_req_o), .arr_gnt_i(arr_gnt_i),
    .tag_rd_en_o(tag_rd_en_o), .tag_rd_idx_o(tag_rd_idx_o), .tag_rd_tag_o(tag_rd_tag_o),
    .tag_rd_hit_i(tag_rd_hit_i), .tag_rd_way_i(tag_rd_way_i), .tag_rd_state_i(tag_rd_state_i),
    .st_wr_en_o(st_wr_en_o), .st_wr_idx_o(st_wr_idx_o), .st_wr_way_o(st_wr_way_o),
    .st_wr_state_o(st_wr_state_o),
    .data_rd_en_o(data_rd_en_o), .data_rd_idx_o(data_rd_idx_o), .data_rd_way_o(data_rd_way_o),
    .data_rd_data_i(data_rd_data_i),
    .snoop_hit_cnt_o(snoop_hit_cnt_o), .snoop_wb_cnt_o(snoop_wb_cnt_o)
  );

  l1_snoop_responder #(.CNT_WIDTH(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .snoop_valid_i(snoop_valid_i), .snoop_ready_o(s_ready),
    .snoop_addr_i(snoop_addr_i), .snoop_type_i(snoop_type_i),
    .snoop_rsp_valid_o(s_rv), .snoop_rsp_hit_o(s_rh),
    .snoop_rsp_data_valid_o(s_rdv), .snoop_rsp_data_o(s_rdata),
    .arr_req_o(s_req), .arr_gnt_i(arr_gnt_i),
    .tag_rd_en_o(s_tre), .tag_rd_idx_o(s_tidx), .tag_rd_tag_o(s_ttag),
    .tag_rd_hit_i(tag_rd_hit_i), .tag_rd_way_i(tag_rd_way_i), .tag_rd_state_i(tag_rd_state_i),
    .st_wr_en_o(s_swe), .st_wr_idx_o(s_sidx), .st_wr_way_o(s_sway), .st_wr_state_o(s_sst),
    .data_rd_en_o(s_dre), .data_rd_idx_o(s_didx), .data_rd_way_o(s_dway),
    .data_rd_data_i(data_rd_data_i),
    .snoop_hit_cnt_o(s_hcnt), .snoop_wb_cnt_o(s_wcnt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Observations gathered across one snoop
  int           r_lat, r_nwr, r_ndrd, r_ntag, r_rdy;
  logic [1:0]   r_wst, r_wway, r_dway;
  logic [5:0]   r_widx, r_didx, r_tidx;
  logic [20:0]  r_ttag;
  logic         r_hit, r_dv;
  logic [255:0] r_data;

  // Issue one snoop, withhold grant for gdelay LOOKUP cycles, observe until the response
  task automatic do_snoop(input logic [1:0] typ, input logic [31:0] addr, input int gdelay);
    int withheld;
    withheld = 0;
    r_lat = -1; r_nwr = 0; r_ndrd = 0; r_ntag = 0; r_rdy = 0;
    r_wst = 2'b00; r_wway = 2'b00; r_dway = 2'b00;
    r_widx = '0; r_didx = '0; r_tidx = '0; r_ttag = '0;
    r_hit = 1'b0; r_dv = 1'b0; r_data = '0;
    @(negedge clk_i);
    snoop_type_i  = typ;
    snoop_addr_i  = addr;
    snoop_valid_i = 1'b1;
    #1;
    chk("ready_before_accept", 256'(snoop_ready_o), 256'(1));
    @(posedge clk_i);
    #1 snoop_valid_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (arr_req_o) begin
        if (withheld < gdelay) begin
          gnt_allow = 1'b0;
          withheld++;
        end else begin
          gnt_allow = 1'b1;
        end
      end else begin
        gnt_allow = 1'b0;
      end
      #1;
      if (snoop_ready_o) r_rdy++;
      if (tag_rd_en_o) begin
        r_ntag++; r_tidx = tag_rd_idx_o; r_ttag = tag_rd_tag_o;
      end
      if (st_wr_en_o) begin
        r_nwr++; r_wst = st_wr_state_o; r_widx = st_wr_idx_o; r_wway = st_wr_way_o;
      end
      if (data_rd_en_o) begin
        r_ndrd++; r_didx = data_rd_idx_o; r_dway = data_rd_way_o;
      end
      if (snoop_rsp_valid_o) begin
        r_lat = k + 1; r_hit = snoop_rsp_hit_o; r_dv = snoop_rsp_data_valid_o;
        r_data = snoop_rsp_data_o;
        break;
      end
    end
    if (r_lat < 0) chk("rsp_timeout", 256'(0), 256'(1));
    @(posedge clk_i);
    #1;
    chk("rsp_single_pulse", 256'(snoop_rsp_valid_o), 256'(0));
    chk("ready_after_rsp", 256'(snoop_ready_o), 256'(1));
    gnt_allow = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic        hit;
    logic [1:0]  st;
    logic [1:0]  way;
    logic        e_hit;
    logic        e_dv;
    int          e_nwr;
    logic [1:0]  e_wst;
    int          e_ndrd;
    int          e_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst_i = 1'b1; snoop_valid_i = 1'b0; snoop_addr_i = '0; snoop_type_i = 2'b00;
    gnt_allow = 1'b0; tag_rd_hit_i = 1'b0; tag_rd_way_i = 2'b00; tag_rd_state_i = 2'b00;
    data_rd_data_i = '0;

    //          typ    addr           hit   st     way    hit   dv  nwr wst   ndrd lat
    vecs[0] = '{2'b00, 32'h1234_5660, 1'b1, 2'b11, 2'd2, 1'b1, 1'b1, 1, 2'b01, 1, 4}; // READ M
    vecs[1] = '{2'b10, 32'hABCD_0020, 1'b1, 2'b10, 2'd1, 1'b1, 1'b0, 1, 2'b00, 0, 3}; // INV E
    vecs[2] = '{2'b00, 32'h0000_07E0, 1'b1, 2'b01, 2'd3, 1'b1, 1'b0, 0, 2'b00, 0, 3}; // READ S
    vecs[3] = '{2'b00, 32'hFFFF_F800, 1'b0, 2'b11, 2'd0, 1'b0, 1'b0, 0, 2'b00, 0, 3}; // READ miss
    vecs[4] = '{2'b01, 32'h8000_0140, 1'b1, 2'b11, 2'd3, 1'b1, 1'b1, 1, 2'b00, 1, 4}; // WRITE M
    vecs[5] = '{2'b01, 32'h0F0F_03A0, 1'b1, 2'b01, 2'd0, 1'b1, 1'b0, 1, 2'b00, 0, 3}; // WRITE S
    vecs[6] = '{2'b10, 32'h5555_5540, 1'b1, 2'b11, 2'd1, 1'b1, 1'b1, 1, 2'b00, 1, 4}; // INV M
    vecs[7] = '{2'b00, 32'h2468_ACE0, 1'b1, 2'b10, 2'd2, 1'b1, 1'b0, 1, 2'b01, 0, 3}; // READ E
    vecs[8] = '{2'b00, 32'h1357_9BC0, 1'b1, 2'b00, 2'd1, 1'b0, 1'b0, 0, 2'b00, 0, 3}; // hit in I
    vecs[9] = '{2'b11, 32'h7777_7700, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0, 0, 2'b00, 0, 1}; // reserved

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", 256'(snoop_ready_o), 256'(1));
    chk("rst_rsp_valid", 256'(snoop_rsp_valid_o), 256'(0));
    chk("rst_arr_req", 256'(arr_req_o), 256'(0));
    chk("rst_strobes", 256'({tag_rd_en_o, st_wr_en_o, data_rd_en_o}), 256'(0));
    chk("rst_rsp_data", snoop_rsp_data_o, 256'(0));
    chk("rst_counters", 256'({snoop_hit_cnt_o, snoop_wb_cnt_o}), 256'(0));

    for (int i = 0; i < 10; i++) begin
      logic [255:0] line;
      line = {8{vecs[i].addr ^ 32'hA5A5_0000}};
      data_rd_data_i = line;
      tag_rd_hit_i   = vecs[i].hit;
      tag_rd_state_i = vecs[i].st;
      tag_rd_way_i   = vecs[i].way;
      do_snoop(vecs[i].typ, vecs[i].addr, 0);
      chk($sformatf("v%0d_latency", i), 256'(r_lat), 256'(vecs[i].e_lat));
      chk($sformatf("v%0d_hit", i), 256'(r_hit), 256'(vecs[i].e_hit));
      chk($sformatf("v%0d_data_valid", i), 256'(r_dv), 256'(vecs[i].e_dv));
      chk($sformatf("v%0d_data", i), r_data, vecs[i].e_dv ? line : 256'(0));
      chk($sformatf("v%0d_st_wr_cnt", i), 256'(r_nwr), 256'(vecs[i].e_nwr));
      chk($sformatf("v%0d_data_rd_cnt", i), 256'(r_ndrd), 256'(vecs[i].e_ndrd));
      chk($sformatf("v%0d_tag_rd_cnt", i), 256'(r_ntag), 256'((vecs[i].typ == 2'b11) ? 0 : 1));
      chk($sformatf("v%0d_ready_busy", i), 256'(r_rdy), 256'(0));
      if (vecs[i].e_nwr != 0) begin
        chk($sformatf("v%0d_st_wr_state", i), 256'(r_wst), 256'(vecs[i].e_wst));
        chk($sformatf("v%0d_st_wr_idx", i), 256'(r_widx), 256'(vecs[i].addr[10:5]));
        chk($sformatf("v%0d_st_wr_way", i), 256'(r_wway), 256'(vecs[i].way));
      end
      if (vecs[i].e_ndrd != 0) begin
        chk($sformatf("v%0d_data_rd_idx", i), 256'(r_didx), 256'(vecs[i].addr[10:5]));
        chk($sformatf("v%0d_data_rd_way", i), 256'(r_dway), 256'(vecs[i].way));
      end
      if (r_ntag != 0) begin
        chk($sformatf("v%0d_tag_idx", i), 256'(r_tidx), 256'(vecs[i].addr[10:5]));
        chk($sformatf("v%0d_tag_tag", i), 256'(r_ttag), 256'(vecs[i].addr[31:11]));
      end
    end

    // 7 hits, 3 dirty responses so far; the 2-bit twin saturates its hit count
    chk("hit_cnt_table", 256'(snoop_hit_cnt_o), 256'(7));
    chk("wb_cnt_table", 256'(snoop_wb_cnt_o), 256'(3));
    chk("sat_hit_cnt_hold", 256'(s_hcnt), 256'(3));
    chk("sat_wb_cnt_full", 256'(s_wcnt), 256'(3));

    // Grant withheld for 5 LOOKUP cycles on a READ of an M line
    tag_rd_hit_i = 1'b1; tag_rd_state_i = 2'b11; tag_rd_way_i = 2'd1;
    data_rd_data_i = {8{32'hDEAD_BEEF}};
    do_snoop(2'b00, 32'h0000_0A80, 5);
    chk("stall_latency", 256'(r_lat), 256'(9));
    chk("stall_tag_rd_cnt", 256'(r_ntag), 256'(1));
    chk("stall_ready_busy", 256'(r_rdy), 256'(0));
    chk("stall_data", r_data, {8{32'hDEAD_BEEF}});
    chk("stall_st_wr_state", 256'(r_wst), 256'(2'b01));
    chk("hit_cnt_stall", 256'(snoop_hit_cnt_o), 256'(8));
    chk("wb_cnt_stall", 256'(snoop_wb_cnt_o), 256'(4));
    chk("sat_wb_cnt_hold", 256'(s_wcnt), 256'(3));
    chk("sat_hit_cnt_hold2", 256'(s_hcnt), 256'(3));

    // Reset while TAG_CHK holds a pending M hit
    @(negedge clk_i);
    snoop_type_i = 2'b00; snoop_addr_i = 32'h0000_0C00; snoop_valid_i = 1'b1;
    @(posedge clk_i);
    #1 snoop_valid_i = 1'b0;
    @(negedge clk_i);
    gnt_allow = 1'b1;
    #1 chk("rstseq_tag_rd", 256'(tag_rd_en_o), 256'(1));
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 chk("rstseq_no_st_wr_in_rst", 256'({st_wr_en_o, data_rd_en_o}), 256'(0));
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    gnt_allow = 1'b0;
    @(negedge clk_i);
    chk("rstseq_ready", 256'(snoop_ready_o), 256'(1));
    chk("rstseq_counters", 256'({snoop_hit_cnt_o, snoop_wb_cnt_o}), 256'(0));
    chk("rstseq_sat_counters", 256'({s_hcnt, s_wcnt}), 256'(0));
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk_i);
        if (snoop_rsp_valid_o || st_wr_en_o || data_rd_en_o || arr_req_o) seen++;
      end
      chk("rstseq_quiet", 256'(seen), 256'(0));
    end

    // A clean snoop after the abandoned one
    tag_rd_hit_i = 1'b1; tag_rd_state_i = 2'b01; tag_rd_way_i = 2'd0;
    do_snoop(2'b00, 32'h0000_0C00, 0);
    chk("post_rst_latency", 256'(r_lat), 256'(3));
    chk("post_rst_hit", 256'(r_hit), 256'(1));
    chk("post_rst_st_wr_cnt", 256'(r_nwr), 256'(0));
    chk("post_rst_hit_cnt", 256'(snoop_hit_cnt_o), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
